// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the R/I/J CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        RST_IDLE = 2'd0,
        REQ      = 2'd1,
        EXEC     = 2'd2
    } fetch_state_t;

    // Next-PC select encodings, shared with the instruction decoder.
    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_JR  = 2'b01;
    localparam logic [1:0] PCS_BR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module   : next_pc_calc
// Brief    : Combinational next-PC selection (sequential, jr, branch, jump).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  PC_s,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] w_br_offset;

    assign w_br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        case (PC_s)
            PCS_SEQ: next_pc = pc_plus4;
            PCS_JR: begin
                // Low bits are forced to zero; a non-zero value is only flagged.
                next_pc  = {rs_data[31:2], 2'b00};
                misalign = |rs_data[1:0];
            end
            PCS_BR:  next_pc = pc_plus4 + w_br_offset;
            PCS_J:   next_pc = {pc_plus4[31:28], instr_index, 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register and instruction fetch over a ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic [1:0]  PC_s,
    input  logic [31:0] rs_data,
    output logic        instr_valid,
    output logic [5:0]  OP,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] instr_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        align_err
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic         r_imem_req;
    logic         r_instr_valid;
    logic         r_align_err;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_misalign;

    assign w_pc_plus4 = r_pc + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4    (w_pc_plus4),
        .PC_s        (PC_s),
        .imm16       (r_ir[15:0]),
        .instr_index (r_ir[25:0]),
        .rs_data     (rs_data),
        .next_pc     (w_next_pc),
        .misalign    (w_misalign)
    );

    // Request and valid are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RST_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= 32'h0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_align_err   <= 1'b0;
        end else begin
            case (r_state)
                RST_IDLE: begin
                    r_state    <= REQ;
                    r_imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        r_ir          <= imem_rdata;
                        r_state       <= EXEC;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!hold) begin
                        r_pc          <= w_next_pc;
                        r_align_err   <= r_align_err | w_misalign;
                        r_state       <= REQ;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= RST_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign OP          = r_ir[31:26];
    assign func        = r_ir[5:0];
    assign rs          = r_ir[25:21];
    assign rt          = r_ir[20:16];
    assign rd          = r_ir[15:11];
    assign imm16       = r_ir[15:0];
    assign instr_index = r_ir[25:0];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign align_err   = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed self-checking bench for pc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        hold;
    logic [1:0]  PC_s;
    logic [31:0] rs_data;
    logic        instr_valid;
    logic [5:0]  OP;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .hold        (hold),
        .PC_s        (PC_s),
        .rs_data     (rs_data),
        .instr_valid (instr_valid),
        .OP          (OP),
        .func        (func),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .instr_index (instr_index),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        hold       = 1'b0;
        PC_s       = 2'b00;
        rs_data    = 32'h0;
        tick();
        tick();

        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_op",    {26'd0, OP},          32'd0);
        chk("rst_func",  {26'd0, func},        32'd0);
        chk("rst_align", {31'd0, align_err},   32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);

        // RST_IDLE -> REQ at address 0
        tick();
        chk("req0_req",   {31'd0, imem_req},    32'd1);
        chk("req0_addr",  imem_addr,            32'h0);
        chk("req0_valid", {31'd0, instr_valid}, 32'd0);

        // addi fetched
        tick();
        chk("addi_valid", {31'd0, instr_valid}, 32'd1);
        chk("addi_op",    {26'd0, OP},          32'h08);
        chk("addi_rt",    {27'd0, rt},          32'd8);
        chk("addi_imm",   {16'd0, imm16},       32'h5);
        chk("addi_req",   {31'd0, imem_req},    32'd0);
        chk("addi_pc4",   pc_plus4,             32'h4);
        PC_s = 2'b00;

        tick();
        chk("req4_addr",  imem_addr,            32'h4);
        chk("req4_valid", {31'd0, instr_valid}, 32'd0);

        // Three cycles without ready: garbage data must not load
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req",   {31'd0, imem_req},    32'd1);
            chk("wait_addr",  imem_addr,            32'h4);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            chk("wait_op",    {26'd0, OP},          32'h08);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0020;

        tick();
        chk("add_valid", {31'd0, instr_valid}, 32'd1);
        chk("add_func",  {26'd0, func},        32'h20);
        chk("add_op",    {26'd0, OP},          32'h0);
        PC_s       = 2'b00;
        imem_rdata = 32'h0800_0040;

        tick();
        chk("req8_addr", imem_addr, 32'h8);
        tick();
        chk("j1_valid", {31'd0, instr_valid}, 32'd1);
        chk("j1_op",    {26'd0, OP},          32'h02);
        chk("j1_index", {6'd0, instr_index},  32'h40);
        PC_s       = 2'b11;
        imem_rdata = 32'h1000_FFFE;

        tick();
        chk("req100_addr", imem_addr, 32'h100);
        tick();
        chk("brn_imm", {16'd0, imm16}, 32'hFFFE);
        PC_s       = 2'b10;
        imem_rdata = 32'h0800_0040;

        tick();
        chk("brn_addr", imem_addr, 32'hFC);
        tick();
        PC_s       = 2'b11;
        imem_rdata = 32'h1000_0003;

        tick();
        chk("jback_addr", imem_addr, 32'h100);
        tick();
        chk("brp_imm", {16'd0, imm16}, 32'h3);
        PC_s       = 2'b10;
        imem_rdata = 32'h03E0_0008;

        tick();
        chk("brp_addr", imem_addr, 32'h110);
        tick();
        chk("jr_func", {26'd0, func}, 32'h08);
        chk("jr_rs",   {27'd0, rs},   32'd31);
        PC_s       = 2'b01;
        rs_data    = 32'hF000_0010;
        imem_rdata = 32'h0800_0040;

        tick();
        chk("jrok_addr",  imem_addr,          32'hF000_0010);
        chk("jrok_align", {31'd0, align_err}, 32'd0);
        tick();
        chk("jhi_pc4", pc_plus4, 32'hF000_0014);
        PC_s       = 2'b11;
        imem_rdata = 32'h03E0_0008;

        tick();
        chk("jhi_addr", imem_addr, 32'hF000_0100);
        tick();
        // Hold four cycles; select/rs changes during hold must be ignored
        hold       = 1'b1;
        PC_s       = 2'b11;
        rs_data    = 32'h0000_0003;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_pc",    pc,                   32'hF000_0100);
            chk("hold_func",  {26'd0, func},        32'h08);
            chk("hold_req",   {31'd0, imem_req},    32'd0);
            chk("hold_align", {31'd0, align_err},   32'd0);
        end
        hold    = 1'b0;
        PC_s    = 2'b01;
        rs_data = 32'h0000_2003;
        imem_rdata = 32'h2008_0005;

        tick();
        chk("jrbad_addr",  imem_addr,          32'h2000);
        chk("jrbad_align", {31'd0, align_err}, 32'd1);
        PC_s    = 2'b00;
        rs_data = 32'h0;
        tick();
        chk("sticky_align1", {31'd0, align_err}, 32'd1);
        tick();
        chk("seq_addr",      imem_addr,          32'h2004);
        chk("sticky_align2", {31'd0, align_err}, 32'd1);

        // Reset asserted during a REQ wait
        imem_ready = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imem_req},    32'd0);
        chk("arst_pc",    pc,                   32'h0);
        chk("arst_align", {31'd0, align_err},   32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        chk("inrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("inrst_req",   {31'd0, imem_req},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_req",   {31'd0, imem_req},    32'd1);
        chk("post_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_addr",  imem_addr,            32'h0);
        tick();
        chk("post_exec",  {31'd0, instr_valid}, 32'd1);
        chk("post_func",  {26'd0, func},        32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
